// File: rtl/fp16_systolic_input_skewer_pkg.sv
// -----------------------------------------------------------------------------
// fp16_systolic_input_skewer_pkg
//
// Purpose:
//   Shared definitions for the FP16 systolic-array input skewer: the FP16 word
//   width and zero constant, the skewer FSM state encoding, and the entry that
//   travels down each lane's delay line.
//
// Contents:
//   FP16_W          - width of one FP16 word (16)
//   FP16_ZERO       - FP16 +0.0, used as the data value of a bubble
//   skew_state_e    - IDLE / STREAM / FLUSH encoding
//   lane_entry_t    - {data, valid, first} carried by every delay tap
//   make_entry()    - builds one lane entry from an accept decision
// -----------------------------------------------------------------------------
package fp16_systolic_input_skewer_pkg;

    localparam int unsigned FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } skew_state_e;

    // One slot of a lane delay line. 'first' marks the opening beat of a tile
    // and becomes the MAC acc_clear when it reaches the end of the lane.
    typedef struct packed {
        logic [FP16_W-1:0] data;
        logic              valid;
        logic              first;
    } lane_entry_t;

    // A non-accepted cycle still inserts an entry (a bubble) so that every
    // lane advances in lock-step; bubbles carry zero data and no flags.
    function automatic lane_entry_t make_entry(input logic              accept,
                                               input logic              first_beat,
                                               input logic [FP16_W-1:0] data);
        lane_entry_t e;
        e.data  = accept ? data : FP16_ZERO;
        e.valid = accept;
        e.first = accept & first_beat;
        return e;
    endfunction

endpackage

// File: rtl/fp16_lane_delay.sv
// -----------------------------------------------------------------------------
// fp16_lane_delay
//
// Purpose:
//   Fixed-depth register chain for one skewer lane. Every cycle the entry on
//   entry_i is shifted in and the oldest entry appears on entry_o, so an entry
//   inserted in cycle t is presented in cycle t+DEPTH.
//
// Parameters:
//   DEPTH    - number of register stages (>= 1)
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset, clears every tap
//   entry_i  - entry inserted this cycle (data, valid, first)
//   entry_o  - entry inserted DEPTH cycles ago
// -----------------------------------------------------------------------------
module fp16_lane_delay
    import fp16_systolic_input_skewer_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  lane_entry_t entry_i,
    output lane_entry_t entry_o
);

    lane_entry_t taps_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                taps_q[k] <= '0;
            end
        end else begin
            taps_q[0] <= entry_i;
            for (int k = 1; k < DEPTH; k++) begin
                taps_q[k] <= taps_q[k-1];
            end
        end
    end

    // Output comes straight from the last register: no combinational path
    // from the lane input to the MAC operand.
    assign entry_o = taps_q[DEPTH-1];

endmodule

// File: rtl/fp16_systolic_input_skewer.sv
// -----------------------------------------------------------------------------
// fp16_systolic_input_skewer
//
// Purpose:
//   Accepts a tile of FP16 vectors and feeds them diagonally into the rows of
//   a systolic MAC array: lane i sees each vector i+1 cycles after it was
//   accepted. Stalls on in_valid become bubbles that travel with the same
//   skew, so lanes never drift apart. After the last vector the block flushes
//   for LANES cycles and pulses done as the last lane shows the last vector.
//
// Parameters:
//   LANES      - number of array rows fed (2..16)
//   LEN_W      - width of tile_len
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   start      - tile start request, looked at only while idle
//   tile_len   - vectors in the tile, latched on an accepted start (0 ignored)
//   in_valid   - in_data holds a vector
//   in_ready   - vector accepted this cycle if in_valid is also high
//   in_data    - FP16 vector, lane i at bits [16i+15:16i]
//   out_data   - skewed FP16 per lane (MAC a_in)
//   out_valid  - per-lane valid (MAC enable)
//   acc_clear  - per-lane first-beat flag (MAC acc_clear)
//   busy       - tile in progress (STREAM or FLUSH)
//   done       - one-cycle tile-complete pulse
//
// Handshake: a beat transfers on a cycle where in_valid && in_ready. in_ready
// depends only on the state register, never on in_valid, and in_data must be
// stable while in_valid is high and the beat has not yet transferred.
// -----------------------------------------------------------------------------
module fp16_systolic_input_skewer
    import fp16_systolic_input_skewer_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LEN_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        tile_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FP16_W*LANES-1:0] in_data,
    output logic [FP16_W*LANES-1:0] out_data,
    output logic [LANES-1:0]        out_valid,
    output logic [LANES-1:0]        acc_clear,
    output logic                    busy,
    output logic                    done
);

    if (LANES < 2 || LANES > 16) begin : g_bad_lanes
        $error("fp16_systolic_input_skewer: LANES must be in 2..16");
    end

    // Flush counter only needs to reach LANES-1.
    localparam int FL_W = $clog2(LANES);
    localparam logic [FL_W-1:0] FLUSH_LAST     = FL_W'(LANES - 1);
    localparam logic [FL_W-1:0] FLUSH_PRE_LAST = FL_W'(LANES - 2);

    skew_state_e      state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] beat_cnt_q;
    logic [FL_W-1:0]  flush_cnt_q;
    logic             done_q;

    logic accept;
    logic first_beat;
    logic last_beat;

    assign in_ready   = (state_q == ST_STREAM);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

    assign accept     = in_valid && in_ready;
    assign first_beat = (beat_cnt_q == '0);
    // Compare against len-1 so a full-range tile_len never needs a wider counter.
    assign last_beat  = (beat_cnt_q == (len_q - LEN_W'(1)));

    // -------------------------------------------------------------------------
    // Tile control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            beat_cnt_q  <= '0;
            flush_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && (tile_len != '0)) begin
                        len_q      <= tile_len;
                        beat_cnt_q <= '0;
                        state_q    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept) begin
                        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        if (last_beat) begin
                            flush_cnt_q <= '0;
                            state_q     <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The final beat was inserted in the last STREAM cycle, so
                    // the last lane (depth LANES) shows it in FLUSH cycle
                    // LANES-1; done is registered one cycle ahead to line up.
                    if (flush_cnt_q == FLUSH_PRE_LAST) begin
                        done_q <= 1'b1;
                    end
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FL_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-lane delay lines; lane i has depth i+1
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lane_entry_t lane_in;
        lane_entry_t lane_out;

        // Insertion happens every cycle, accepted or not, in every state.
        assign lane_in = make_entry(accept, first_beat,
                                    in_data[FP16_W*i +: FP16_W]);

        fp16_lane_delay #(
            .DEPTH (i + 1)
        ) u_delay (
            .clk     (clk),
            .rst     (rst),
            .entry_i (lane_in),
            .entry_o (lane_out)
        );

        assign out_data[FP16_W*i +: FP16_W] = lane_out.data;
        assign out_valid[i]                 = lane_out.valid;
        assign acc_clear[i]                 = lane_out.first & lane_out.valid;
    end

endmodule

// File: doc/fp16_systolic_input_skewer.md
FP16_SYSTOLIC_INPUT_SKEWER -- requirements
Module: fp16_systolic_input_skewer

Interface
REQ-001 SHALL have parameter LANES, default 4: number of array rows fed, legal range 2..16.
REQ-002 SHALL have parameter LEN_W, default 8: width of tile_len.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: tile start request, sampled only in IDLE.
REQ-006 SHALL have port tile_len, input, LEN_W bits: number of input vectors in the tile, latched on an accepted start.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds a vector.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a vector this cycle.
REQ-009 SHALL have port in_data, input, 16*LANES bits: FP16 vector; lane i occupies bits [16i+15:16i].
REQ-010 SHALL have port out_data, output, 16*LANES bits: skewed FP16 per lane, feeding the MAC a_in ports.
REQ-011 SHALL have port out_valid, output, LANES bits: per-lane valid, driving the MAC enable.
REQ-012 SHALL have port acc_clear, output, LANES bits: per-lane first-beat flag, driving the MAC acc_clear.
REQ-013 SHALL have port busy, output, 1 bit: high in STREAM and FLUSH.
REQ-014 SHALL have port done, output, 1 bit: one-cycle tile-complete pulse.

Function
REQ-015 SHALL implement an FSM with states IDLE, STREAM and FLUSH.
REQ-016 In IDLE, start=1 with tile_len!=0 SHALL latch tile_len, clear the beat counter and enter STREAM; start with tile_len=0 SHALL be ignored.
REQ-017 start SHALL be ignored in STREAM and FLUSH.
REQ-018 in_ready SHALL equal (state==STREAM), combinationally from the state register only, with no dependence on in_valid.
REQ-019 A beat SHALL be accepted when in_valid&&in_ready; the accepted-beat count SHALL increment by 1 per beat.
REQ-020 The cycle accepting beat number tile_len SHALL move the FSM to FLUSH.
REQ-021 Lane i SHALL present an entry exactly i+1 cycles after the cycle it was inserted; lane 0 therefore has 1-cycle latency.
REQ-022 Each cycle SHALL insert one entry per lane: in_data with valid=1 on accept, otherwise data 16'h0000 with valid=0 (a bubble).
REQ-023 Bubbles SHALL propagate with the same skew as data, so a stall on in_valid never misaligns lanes.
REQ-024 acc_clear[i] SHALL be 1 only together with out_valid[i] for the first beat of a tile.
REQ-025 Data SHALL pass bit-exact, including 16'h8000, Inf and NaN; there is no arithmetic.
REQ-026 FLUSH SHALL last LANES cycles.
REQ-027 done SHALL pulse in the last FLUSH cycle, which is the same cycle lane LANES-1 presents the final beat; the FSM SHALL then enter IDLE.
REQ-028 A start in the cycle after done SHALL be accepted; earlier-tile entries still in the delay lines SHALL be unaffected.

Reset
REQ-029 While rst=1, the block SHALL force state IDLE, clear all delay taps and counters, and drive out_data=0, out_valid=0, acc_clear=0, in_ready=0, busy=0, done=0.
REQ-030 A reset asserted mid-tile SHALL discard all in-flight beats; there SHALL be no done for the aborted tile.

Structure
REQ-031 A shared package SHALL hold FP16_W=16, FP16_ZERO=16'h0000 and the state encoding.
REQ-032 One sub-module, fp16_lane_delay, SHALL implement a parameterised-depth register chain carrying {data, valid, first}; it SHALL be instantiated once per lane with depth i+1.

Verification
REQ-033 Reset, LANES=4: start, tile_len=3, beats A,B,C with in_valid held high -> lane0 shows A,B,C in cycles 1..3 after accept; lane3 shows A,B,C in cycles 4..6; acc_clear only with A; done in the cycle lane3 shows C.
REQ-034 Same tile with in_valid low for 2 cycles between A and B -> every lane shows A, two bubbles (0, valid 0), B, C at its skew; done is delayed by 2 cycles.
REQ-035 start with tile_len=0 -> FSM stays IDLE; busy=0; no done.
REQ-036 start asserted during STREAM -> ignored; the tile_len latched at the accepted start still governs the tile.
REQ-037 rst pulsed after beat B of a 3-beat tile -> all outputs 0 next cycle; no done; a new tile after reset runs normally.
REQ-038 A beat carrying 16'h8000, 16'h7C00 and 16'h7E01 in lanes 0..2 -> the same values appear at the correct skews, unmodified.
